// File: rtl/riscv_pipe5.sv
// rtl/riscv_pipe5.sv - five-stage in-order RISC-V integer pipeline core (IF/ID/EX/MEM/WB)
// Macro RISCV_PIPE_FWD_EN adds EX bypass paths; without it ID interlocks on every RAW hazard.
module riscv_pipe5 #(
   parameter int              XLEN       = 64,
   parameter int              IMEM_WORDS = 1024,
   parameter int              DMEM_WORDS = 1024,
   parameter logic [XLEN-1:0] RESET_PC   = '0
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic [4:0]      dbg_raddr,
   output logic [XLEN-1:0] dbg_rdata,
   output logic [XLEN-1:0] pc_out,
   output logic            stall_out,
   output logic            flush_out,
   output logic            retire_valid,
   output logic [4:0]      retire_rd,
   output logic [XLEN-1:0] retire_data
);
   localparam int          IA      = $clog2(IMEM_WORDS);
   localparam int          DA      = $clog2(DMEM_WORDS);
   localparam int          BSH     = $clog2(XLEN / 8);
   localparam logic [31:0] NOP     = 32'h0000_0013;
   localparam logic [2:0]  F3_LDST = (XLEN == 64) ? 3'b011 : 3'b010;
   localparam logic [6:0]  OPC_OP  = 7'b0110011;
   localparam logic [6:0]  OPC_OPI = 7'b0010011;
   localparam logic [6:0]  OPC_LD  = 7'b0000011;
   localparam logic [6:0]  OPC_SD  = 7'b0100011;
   localparam logic [6:0]  OPC_BR  = 7'b1100011;

   function automatic logic is_op(input logic [31:0] ir);
      if (ir[6:0] != OPC_OP) return 1'b0;
      if (ir[31:25] == 7'b0100000) return ir[14:12] == 3'b000;
      return (ir[31:25] == 7'b0) &&
             (ir[14:12] inside {3'b000, 3'b010, 3'b100, 3'b110, 3'b111});
   endfunction

   function automatic logic is_opi(input logic [31:0] ir);
      return (ir[6:0] == OPC_OPI) && (ir[14:12] inside {3'b000, 3'b100, 3'b110, 3'b111});
   endfunction

   function automatic logic is_ld(input logic [31:0] ir);
      return (ir[6:0] == OPC_LD) && (ir[14:12] == F3_LDST);
   endfunction

   function automatic logic is_sd(input logic [31:0] ir);
      return (ir[6:0] == OPC_SD) && (ir[14:12] == F3_LDST);
   endfunction

   function automatic logic is_br(input logic [31:0] ir);
      return (ir[6:0] == OPC_BR) && (ir[14:13] == 2'b00);
   endfunction

   function automatic logic alu_wr(input logic [31:0] ir);
      return (is_op(ir) || is_opi(ir)) && (ir[11:7] != 5'd0);
   endfunction

   function automatic logic writes_rd(input logic [31:0] ir);
      return (is_op(ir) || is_opi(ir) || is_ld(ir)) && (ir[11:7] != 5'd0);
   endfunction

   // True when the instruction in ir consumes register rd as rs1 or rs2.
   function automatic logic reads_reg(input logic [31:0] ir, input logic [4:0] rd);
      logic r1, r2;
      r1 = is_op(ir) || is_opi(ir) || is_ld(ir) || is_sd(ir) || is_br(ir);
      r2 = is_op(ir) || is_sd(ir) || is_br(ir);
      return (r1 && ir[19:15] == rd) || (r2 && ir[24:20] == rd);
   endfunction

   logic [31:0]     imem [IMEM_WORDS];
   logic [XLEN-1:0] dmem [DMEM_WORDS];
   logic [XLEN-1:0] regs_q [32];

   logic [XLEN-1:0] pc_q, pc_d;
   logic [31:0]     ifid_ir_q, ifid_ir_d;
   logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
   logic [31:0]     idex_ir_q, idex_ir_d;
   logic [XLEN-1:0] idex_pc_q, idex_pc_d;
   logic [XLEN-1:0] idex_a_q, idex_a_d;
   logic [XLEN-1:0] idex_b_q, idex_b_d;
   logic [31:0]     exmem_ir_q;
   logic [XLEN-1:0] exmem_res_q;
   logic [XLEN-1:0] exmem_sdata_q;
   logic [31:0]     memwb_ir_q;
   logic [XLEN-1:0] memwb_res_q;

   logic [XLEN-1:0] id_a, id_b;
   logic [XLEN-1:0] ex_a, ex_b, ex_op2, ex_res;
   logic [XLEN-1:0] imm_i, imm_s, imm_b;
   logic            hazard, flush, stall;
   logic [XLEN-1:0] br_target;
   logic [DA-1:0]   mem_idx;
   logic [XLEN-1:0] wb_val;

   // ID register read, write-through from the WB stage
   always_comb begin
      id_a = regs_q[ifid_ir_q[19:15]];
      id_b = regs_q[ifid_ir_q[24:20]];
      if (writes_rd(memwb_ir_q) && memwb_ir_q[11:7] == ifid_ir_q[19:15]) id_a = memwb_res_q;
      if (writes_rd(memwb_ir_q) && memwb_ir_q[11:7] == ifid_ir_q[24:20]) id_b = memwb_res_q;
   end

`ifdef RISCV_PIPE_FWD_EN
   // EX/MEM ALU results win over MEM/WB; loads in EX/MEM are covered by the interlock
   always_comb begin
      ex_a = idex_a_q;
      ex_b = idex_b_q;
      if (writes_rd(memwb_ir_q) && memwb_ir_q[11:7] == idex_ir_q[19:15]) ex_a = memwb_res_q;
      if (writes_rd(memwb_ir_q) && memwb_ir_q[11:7] == idex_ir_q[24:20]) ex_b = memwb_res_q;
      if (alu_wr(exmem_ir_q) && exmem_ir_q[11:7] == idex_ir_q[19:15]) ex_a = exmem_res_q;
      if (alu_wr(exmem_ir_q) && exmem_ir_q[11:7] == idex_ir_q[24:20]) ex_b = exmem_res_q;
   end

   always_comb begin
      hazard = is_ld(idex_ir_q) && (idex_ir_q[11:7] != 5'd0) &&
               reads_reg(ifid_ir_q, idex_ir_q[11:7]);
   end
`else
   assign ex_a = idex_a_q;
   assign ex_b = idex_b_q;

   // Hold ID until every producer has reached WB, where write-through supplies the value
   always_comb begin
      hazard = (writes_rd(idex_ir_q) && reads_reg(ifid_ir_q, idex_ir_q[11:7])) ||
               (writes_rd(exmem_ir_q) && reads_reg(ifid_ir_q, exmem_ir_q[11:7]));
   end
`endif

   assign imm_i = {{(XLEN-12){idex_ir_q[31]}}, idex_ir_q[31:20]};
   assign imm_s = {{(XLEN-12){idex_ir_q[31]}}, idex_ir_q[31:25], idex_ir_q[11:7]};
   assign imm_b = {{(XLEN-12){idex_ir_q[31]}}, idex_ir_q[7], idex_ir_q[30:25],
                   idex_ir_q[11:8], 1'b0};

   always_comb begin
      ex_op2 = is_op(idex_ir_q) ? ex_b : imm_i;
      ex_res = ex_a + ex_op2;
      if (is_sd(idex_ir_q)) begin
         ex_res = ex_a + imm_s;
      end else if (is_op(idex_ir_q) || is_opi(idex_ir_q)) begin
         case (idex_ir_q[14:12])
            3'b000:  ex_res = (is_op(idex_ir_q) && idex_ir_q[30]) ? ex_a - ex_op2 : ex_a + ex_op2;
            3'b010:  ex_res = {{(XLEN-1){1'b0}}, ($signed(ex_a) < $signed(ex_op2))};
            3'b100:  ex_res = ex_a ^ ex_op2;
            3'b110:  ex_res = ex_a | ex_op2;
            3'b111:  ex_res = ex_a & ex_op2;
            default: ex_res = ex_a + ex_op2;
         endcase
      end
   end

   assign flush     = is_br(idex_ir_q) && ((idex_ir_q[12] == 1'b0) ? (ex_a == ex_b) : (ex_a != ex_b));
   assign br_target = idex_pc_q + imm_b;
   assign stall     = hazard && !flush;

   always_comb begin
      pc_d      = pc_q + XLEN'(4);
      ifid_ir_d = imem[pc_q[2 +: IA]];
      ifid_pc_d = pc_q;
      idex_ir_d = ifid_ir_q;
      idex_pc_d = ifid_pc_q;
      idex_a_d  = id_a;
      idex_b_d  = id_b;
      if (flush) begin
         pc_d      = br_target;
         ifid_ir_d = NOP;
         idex_ir_d = NOP;
      end else if (stall) begin
         pc_d      = pc_q;
         ifid_ir_d = ifid_ir_q;
         ifid_pc_d = ifid_pc_q;
         idex_ir_d = NOP;
      end
   end

   assign mem_idx = exmem_res_q[BSH +: DA];
   assign wb_val  = is_ld(exmem_ir_q) ? dmem[mem_idx] : exmem_res_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pc_q          <= RESET_PC;
         ifid_ir_q     <= NOP;
         ifid_pc_q     <= '0;
         idex_ir_q     <= NOP;
         idex_pc_q     <= '0;
         idex_a_q      <= '0;
         idex_b_q      <= '0;
         exmem_ir_q    <= NOP;
         exmem_res_q   <= '0;
         exmem_sdata_q <= '0;
         memwb_ir_q    <= NOP;
         memwb_res_q   <= '0;
      end else begin
         pc_q          <= pc_d;
         ifid_ir_q     <= ifid_ir_d;
         ifid_pc_q     <= ifid_pc_d;
         idex_ir_q     <= idex_ir_d;
         idex_pc_q     <= idex_pc_d;
         idex_a_q      <= idex_a_d;
         idex_b_q      <= idex_b_d;
         exmem_ir_q    <= idex_ir_q;
         exmem_res_q   <= ex_res;
         exmem_sdata_q <= ex_b;
         memwb_ir_q    <= exmem_ir_q;
         memwb_res_q   <= wb_val;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 32; i++) regs_q[i] <= XLEN'(i);
      end else if (retire_valid) begin
         regs_q[retire_rd] <= retire_data;
      end
   end

   // Reset forces EX/MEM to NOP, so a store caught by reset never writes
   always_ff @(posedge clock) begin
      if (is_sd(exmem_ir_q)) dmem[mem_idx] <= exmem_sdata_q;
   end

   assign dbg_rdata    = regs_q[dbg_raddr];
   assign pc_out       = pc_q;
   assign stall_out    = stall;
   assign flush_out    = flush;
   assign retire_valid = writes_rd(memwb_ir_q);
   assign retire_rd    = memwb_ir_q[11:7];
   assign retire_data  = memwb_res_q;
endmodule

// File: tb/tb_riscv_pipe5.sv
// tb/tb_riscv_pipe5.sv - scoreboard bench for riscv_pipe5 with directed programs
module tb_riscv_pipe5;
`ifdef RISCV_PIPE_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [4:0]  dbg_raddr = 5'd0;
   logic [63:0] dbg_rdata, pc_out, retire_data;
   logic        stall_out, flush_out, retire_valid;
   logic [4:0]  retire_rd;

   riscv_pipe5 #(.XLEN(64), .IMEM_WORDS(1024), .DMEM_WORDS(1024), .RESET_PC(64'd0)) dut (
      .clock(clock), .reset_n(reset_n), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata),
      .pc_out(pc_out), .stall_out(stall_out), .flush_out(flush_out),
      .retire_valid(retire_valid), .retire_rd(retire_rd), .retire_data(retire_data)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [4:0]  rd;
      logic [63:0] data;
   } ret_t;

   ret_t        sb[$];
   logic [31:0] prog[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          stall_cnt = 0;
   int          flush_cnt = 0;
   int          ret_cyc[32];

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) cyc <= 0;
      else          cyc <= cyc + 1;
   end

   always @(negedge clock) begin
      ret_t e;
      if (reset_n) begin
         if (stall_out) stall_cnt++;
         if (flush_out) flush_cnt++;
         if (retire_valid) begin
            checks++;
            ret_cyc[retire_rd] = cyc;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL retire_unexpected actual rd=%0d data=%h required none", retire_rd, retire_data);
            end else begin
               e = sb.pop_front();
               if (retire_rd !== e.rd || retire_data !== e.data) begin
                  errors++;
                  $display("FAIL retire actual rd=%0d data=%h required rd=%0d data=%h",
                           retire_rd, retire_data, e.rd, e.data);
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic chk_reg(input logic [4:0] r, input logic [63:0] exp);
      dbg_raddr = r;
      #1;
      chk($sformatf("x%0d", r), dbg_rdata, exp);
   endtask

   task automatic expect_ret(input logic [4:0] rd, input logic [63:0] data);
      ret_t e;
      e.rd   = rd;
      e.data = data;
      sb.push_back(e);
   endtask

   task automatic load_and_reset();
      reset_n = 1'b0;
      for (int i = 0; i < 1024; i++) dut.imem[i] = NOP;
      for (int i = 0; i < prog.size(); i++) dut.imem[i] = prog[i];
      sb.delete();
      stall_cnt = 0;
      flush_cnt = 0;
      for (int i = 0; i < 32; i++) ret_cyc[i] = -1;
   endtask

   task automatic release_and_run(input int n);
      @(negedge clock);
      reset_n = 1'b1;
      repeat (n) @(negedge clock);
   endtask

   initial begin
      // back-to-back ALU dependence
      prog = '{32'h002081B3, 32'h00318233};
      load_and_reset();
      #1;
      chk("reset_pc", pc_out, 64'd0);
      chk("reset_retire_valid", {63'd0, retire_valid}, 64'd0);
      chk("reset_stall", {63'd0, stall_out}, 64'd0);
      chk("reset_flush", {63'd0, flush_out}, 64'd0);
      expect_ret(5'd3, 64'd3);
      expect_ret(5'd4, 64'd6);
      release_and_run(12);
      chk_reg(5'd3, 64'd3);
      chk_reg(5'd4, 64'd6);
      chk("s1_stalls", 64'(stall_cnt), FWD ? 64'd0 : 64'd2);
      chk("s1_x4_retire_cycle", 64'(ret_cyc[4]), FWD ? 64'd5 : 64'd7);
      chk("s1_drain", 64'(sb.size()), 64'd0);

      // load-use
      prog = '{32'h00003283, 32'h00128333};
      load_and_reset();
      dut.dmem[0] = 64'h55;
      expect_ret(5'd5, 64'h55);
      expect_ret(5'd6, 64'h56);
      release_and_run(12);
      chk_reg(5'd5, 64'h55);
      chk_reg(5'd6, 64'h56);
      chk("s2_stalls", 64'(stall_cnt), FWD ? 64'd1 : 64'd2);
      chk("s2_drain", 64'(sb.size()), 64'd0);

      // taken branch flushes the two following slots
      prog = '{32'h00108663, 32'h00700493, 32'h00700493, 32'h00500513};
      load_and_reset();
      expect_ret(5'd10, 64'd5);
      release_and_run(14);
      chk_reg(5'd9, 64'd9);
      chk_reg(5'd10, 64'd5);
      chk("s3_flushes", 64'(flush_cnt), 64'd1);
      chk("s3_stalls", 64'(stall_cnt), 64'd0);
      chk("s3_drain", 64'(sb.size()), 64'd0);

      // store with forwarded data, then load same address
      prog = '{32'h02A00413, 32'h00803423, 32'h00803383};
      load_and_reset();
      dut.dmem[1] = 64'd0;
      expect_ret(5'd8, 64'd42);
      expect_ret(5'd7, 64'd42);
      release_and_run(14);
      chk("s4_dmem1", dut.dmem[1], 64'd42);
      chk_reg(5'd7, 64'd42);
      chk_reg(5'd8, 64'd42);
      chk("s4_drain", 64'(sb.size()), 64'd0);

      // sub/slt/xori chain, unsupported SLL as NOP, not-taken BNE, negative immediate
      prog = '{32'h405105B3, 32'h0015A633, 32'hFFF5C693, 32'h001097B3, 32'h00109463, 32'hFFF00713};
      load_and_reset();
      expect_ret(5'd11, 64'hFFFF_FFFF_FFFF_FFFD);
      expect_ret(5'd12, 64'd1);
      expect_ret(5'd13, 64'd2);
      expect_ret(5'd14, 64'hFFFF_FFFF_FFFF_FFFF);
      release_and_run(20);
      chk_reg(5'd11, 64'hFFFF_FFFF_FFFF_FFFD);
      chk_reg(5'd12, 64'd1);
      chk_reg(5'd13, 64'd2);
      chk_reg(5'd14, 64'hFFFF_FFFF_FFFF_FFFF);
      chk_reg(5'd15, 64'd15);
      chk("s6_flushes", 64'(flush_cnt), 64'd0);
      chk("s6_drain", 64'(sb.size()), 64'd0);

      // asynchronous reset mid-stream, then clean restart
      prog = '{32'h002081B3, 32'h00318233};
      load_and_reset();
      expect_ret(5'd3, 64'd3);
      expect_ret(5'd4, 64'd6);
      release_and_run(3);
      @(posedge clock);
      #2;
      chk("s5_retire_before_reset", {63'd0, retire_valid}, 64'd1);
      reset_n = 1'b0;
      #1;
      chk("s5_async_pc", pc_out, 64'd0);
      chk("s5_async_retire_valid", {63'd0, retire_valid}, 64'd0);
      chk("s5_async_retire_rd", {59'd0, retire_rd}, 64'd0);
      chk_reg(5'd7, 64'd7);
      sb.delete();
      for (int i = 0; i < 32; i++) ret_cyc[i] = -1;
      stall_cnt = 0;
      expect_ret(5'd3, 64'd3);
      expect_ret(5'd4, 64'd6);
      release_and_run(12);
      chk_reg(5'd4, 64'd6);
      chk("s5_x4_retire_cycle", 64'(ret_cyc[4]), FWD ? 64'd5 : 64'd7);
      chk("s5_drain", 64'(sb.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
